// File: rtl/bsg_sdr_link_reset_sequencer.sv
// -----------------------------------------------------------------------------
// bsg_sdr_link_reset_sequencer
//
// Brings up a group of SDR links by walking their four reset lines through a
// fixed phase order:
//   ASSERT -> TOKEN_SET -> TOKEN_CLR -> REL_UP -> REL_DOWN -> REL_DS -> DONE
// Each of the six working phases lasts H+1 cycles. H is sampled from
// hold_cycles_i when the sequence is accepted. Only the links selected by
// link_mask_i are touched. Unselected links keep whatever values they had.
//
// Optional feature: define BSG_SDR_RESET_SEQ_ABORT_EN to add abort_i. An
// abort puts the selected links back to their ASSERT values and returns to
// IDLE without a done pulse. When the macro is undefined, the port and all of
// its logic are absent.
//
// Parameters
//   num_links_p       number of SDR links sequenced
//   hold_width_p      width of the phase hold count
//
// Ports
//   clk_i             sole clock, rising edge
//   reset_n_i         synchronous active-low reset
//   start_i           request a bring-up sequence (honoured in IDLE, mask != 0)
//   abort_i           (ABORT_EN only) abandon the running sequence
//   link_mask_i       links targeted by start_i
//   hold_cycles_i     phase hold count H
//   uplink_reset_o    per-link uplink reset, active-high
//   downlink_reset_o  per-link downlink reset, active-high
//   downstream_reset_o per-link downstream reset, active-high
//   token_reset_o     per-link token reset, active-high
//   busy_o            high in every state except IDLE
//   done_o            single-cycle completion pulse
// -----------------------------------------------------------------------------
module bsg_sdr_link_reset_sequencer #(
  parameter int num_links_p  = 3,
  parameter int hold_width_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    start_i,
`ifdef BSG_SDR_RESET_SEQ_ABORT_EN
  input  logic                    abort_i,
`endif
  input  logic [num_links_p-1:0]  link_mask_i,
  input  logic [hold_width_p-1:0] hold_cycles_i,
  output logic [num_links_p-1:0]  uplink_reset_o,
  output logic [num_links_p-1:0]  downlink_reset_o,
  output logic [num_links_p-1:0]  downstream_reset_o,
  output logic [num_links_p-1:0]  token_reset_o,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_TOKEN_SET,
    ST_TOKEN_CLR,
    ST_REL_UP,
    ST_REL_DOWN,
    ST_REL_DS,
    ST_DONE
  } state_e;

  state_e                  state, state_next;
  logic [hold_width_p-1:0] cnt, cnt_next;
  logic [hold_width_p-1:0] hold, hold_next;
  logic [num_links_p-1:0]  mask, mask_next;
  logic [num_links_p-1:0]  up, up_next;
  logic [num_links_p-1:0]  down, down_next;
  logic [num_links_p-1:0]  ds, ds_next;
  logic [num_links_p-1:0]  tok, tok_next;
  logic                    phase_end;

  // The counter runs 0..H and is compared for equality rather than counted
  // down past zero. This lets H = all-ones hold for the full 2^W cycles
  // without wrapping.
  assign phase_end = (cnt == hold);

  // Next-state and next-output logic. Output values only change on a phase
  // transition, so each reset line is a pure register output.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    state_next = state;
    cnt_next   = cnt;
    hold_next  = hold;
    mask_next  = mask;
    up_next    = up;
    down_next  = down;
    ds_next    = ds;
    tok_next   = tok;

    unique case (state)
      ST_IDLE: begin
        if (start_i && (|link_mask_i)) begin
          state_next = ST_ASSERT;
          cnt_next   = '0;
          mask_next  = link_mask_i;
          hold_next  = hold_cycles_i;
          // ASSERT values are loaded on the accepting edge so they are
          // visible from the first ASSERT cycle.
          up_next    = up   | link_mask_i;
          down_next  = down | link_mask_i;
          ds_next    = ds   | link_mask_i;
          tok_next   = tok  & ~link_mask_i;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        if (phase_end) begin
          cnt_next = '0;
          case (state)
            ST_ASSERT: begin
              state_next = ST_TOKEN_SET;
              tok_next   = tok | mask;
            end
            ST_TOKEN_SET: begin
              state_next = ST_TOKEN_CLR;
              tok_next   = tok & ~mask;
            end
            ST_TOKEN_CLR: begin
              state_next = ST_REL_UP;
              up_next    = up & ~mask;
            end
            ST_REL_UP: begin
              state_next = ST_REL_DOWN;
              down_next  = down & ~mask;
            end
            ST_REL_DOWN: begin
              state_next = ST_REL_DS;
              ds_next    = ds & ~mask;
            end
            default: begin
              state_next = ST_DONE;
            end
          endcase
        end else begin
          cnt_next = cnt + hold_width_p'(1);
        end
      end
    endcase

`ifdef BSG_SDR_RESET_SEQ_ABORT_EN
    // An abort overrides everything above, including a start that arrives on
    // the same edge. The selected links fall back to their ASSERT values.
    if (abort_i && (state != ST_IDLE)) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      up_next    = up   | mask;
      down_next  = down | mask;
      ds_next    = ds   | mask;
      tok_next   = tok  & ~mask;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before this edge.
    if (!reset_n_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hold  <= '0;
      mask  <= '0;
      up    <= '1;
      down  <= '1;
      ds    <= '1;
      tok   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      hold  <= hold_next;
      mask  <= mask_next;
      up    <= up_next;
      down  <= down_next;
      ds    <= ds_next;
      tok   <= tok_next;
    end
  end

  assign uplink_reset_o     = up;
  assign downlink_reset_o   = down;
  assign downstream_reset_o = ds;
  assign token_reset_o      = tok;
  assign busy_o             = (state != ST_IDLE);
  assign done_o             = (state == ST_DONE);

endmodule

// File: tb/tb_bsg_sdr_link_reset_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for bsg_sdr_link_reset_sequencer.
//
// The reference model tracks only two things: how many cycles have passed
// since a sequence was accepted, and the reset values at that moment. From
// these it derives the phase index and each expected output. A compare
// process checks every output on every falling edge. Directed scenarios add
// hand-computed literal checks: done timing, final values, and ignored
// starts.
//
// Define BSG_SDR_RESET_SEQ_ABORT_EN for both files to exercise abort_i.
// -----------------------------------------------------------------------------
module tb_bsg_sdr_link_reset_sequencer;
  localparam int N  = 3;
  localparam int HW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [N-1:0]  mask_in;
  logic [HW-1:0] hold_in;
`ifdef BSG_SDR_RESET_SEQ_ABORT_EN
  logic          abort;
`endif
  logic [N-1:0]  up, down, ds, tok;
  logic          busy, done;

  always #5 clk = ~clk;

  bsg_sdr_link_reset_sequencer #(
    .num_links_p (N),
    .hold_width_p(HW)
  ) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .start_i           (start),
`ifdef BSG_SDR_RESET_SEQ_ABORT_EN
    .abort_i           (abort),
`endif
    .link_mask_i       (mask_in),
    .hold_cycles_i     (hold_in),
    .uplink_reset_o    (up),
    .downlink_reset_o  (down),
    .downstream_reset_o(ds),
    .token_reset_o     (tok),
    .busy_o            (busy),
    .done_o            (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           cyc = 0;
  bit           armed = 0;
  bit           m_active = 0;
  int           m_c, m_h;
  logic [N-1:0] m_mask;
  logic [N-1:0] b_up, b_down, b_ds, b_tok;
  logic [N-1:0] e_up, e_down, e_ds, e_tok;
  bit           e_busy, e_done;

  // Phase p: 0..5 are the six working phases, and 6 is DONE. A selected line
  // stays asserted until its release phase begins.
  task automatic apply_phase();
    int p;
    if (m_c <= 6 * (m_h + 1)) p = (m_c - 1) / (m_h + 1);
    else p = 6;
    e_up   = (b_up   & ~m_mask) | ((p < 3) ? m_mask : '0);
    e_down = (b_down & ~m_mask) | ((p < 4) ? m_mask : '0);
    e_ds   = (b_ds   & ~m_mask) | ((p < 5) ? m_mask : '0);
    e_tok  = (b_tok  & ~m_mask) | ((p == 1) ? m_mask : '0);
    e_busy = 1'b1;
    e_done = (p == 6);
  endtask

  always @(posedge clk) begin
    cyc++;
    armed = 1'b1;
    if (!reset_n) begin
      m_active = 0;
      e_up = '1; e_down = '1; e_ds = '1; e_tok = '0;
      e_busy = 0; e_done = 0;
    end
`ifdef BSG_SDR_RESET_SEQ_ABORT_EN
    else if (abort && m_active) begin
      m_active = 0;
      e_up = e_up | m_mask; e_down = e_down | m_mask; e_ds = e_ds | m_mask;
      e_tok = e_tok & ~m_mask;
      e_busy = 0; e_done = 0;
    end
`endif
    else if (m_active) begin
      m_c++;
      if (m_c > 6 * (m_h + 1) + 1) begin
        m_active = 0; e_busy = 0; e_done = 0;
      end else begin
        apply_phase();
      end
    end else if (start && (mask_in != '0)) begin
      m_active = 1;
      m_c = 1;
      m_mask = mask_in;
      m_h = int'(hold_in);
      b_up = e_up; b_down = e_down; b_ds = e_ds; b_tok = e_tok;
      apply_phase();
    end
  end

  // ---------------- per-cycle compare ----------------
  int done_cnt = 0;
  int last_done = 0;
  int tok0_cnt = 0;

  always @(negedge clk) begin
    if (armed) begin
      check("uplink", {29'b0, up}, {29'b0, e_up});
      check("downlink", {29'b0, down}, {29'b0, e_down});
      check("downstream", {29'b0, ds}, {29'b0, e_ds});
      check("token", {29'b0, tok}, {29'b0, e_tok});
      check("busy", {31'b0, busy}, {31'b0, e_busy});
      check("done", {31'b0, done}, {31'b0, e_done});
      if (done) begin
        done_cnt++;
        last_done = cyc;
      end
      if (tok[0]) tok0_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a falling edge. Presents start for one rising edge and
  // returns the index of the accepting edge.
  task automatic kick(input logic [N-1:0] m, input int h, output int t);
    start = 1'b1; mask_in = m; hold_in = HW'(h);
    @(posedge clk); #1 t = cyc;
    @(negedge clk);
    start = 1'b0; mask_in = '0; hold_in = '0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!busy) break;
    end
    check("idle_reached", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int t, dc0;
    reset_n = 1'b0; start = 1'b0; mask_in = '0; hold_in = '0;
`ifdef BSG_SDR_RESET_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk); #1;
    check("rst_up", {29'b0, up}, 32'h7);
    check("rst_down", {29'b0, down}, 32'h7);
    check("rst_ds", {29'b0, ds}, 32'h7);
    check("rst_tok", {29'b0, tok}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);

    // Mask 101, H = 2: done 19 cycles after acceptance.
    @(negedge clk);
    dc0 = done_cnt;
    kick(3'b101, 2, t);
    wait_idle(100);
    check("s1_done_count", done_cnt - dc0, 1);
    check("s1_done_at", last_done - t + 1, 19);
    check("s1_up", {29'b0, up}, 32'h2);
    check("s1_down", {29'b0, down}, 32'h2);
    check("s1_ds", {29'b0, ds}, 32'h2);
    check("s1_tok", {29'b0, tok}, 32'h0);

    // H = 0, mask 001: done at +7, token[0] high for exactly one cycle.
    @(negedge clk);
    tok0_cnt = 0;
    kick(3'b001, 0, t);
    wait_idle(50);
    check("s2_done_at", last_done - t + 1, 7);
    check("s2_tok0_cycles", tok0_cnt, 1);

    // A start while busy and a start with a zero mask are both ignored.
    @(negedge clk);
    dc0 = done_cnt;
    kick(3'b010, 3, t);
    repeat (5) @(negedge clk);
    start = 1'b1; mask_in = 3'b100; hold_in = 8'd0;
    @(negedge clk);
    start = 1'b0; mask_in = '0;
    wait_idle(100);
    check("s3_done_count", done_cnt - dc0, 1);
    check("s3_done_at", last_done - t + 1, 25);
    start = 1'b1; mask_in = 3'b000; hold_in = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk); #1;
    check("s3_mask0_busy", {31'b0, busy}, 32'd0);
    check("s3_mask0_done", done_cnt - dc0, 1);

    // Reset during REL_DOWN (H = 1, cycles 9..10 after acceptance).
    dc0 = done_cnt;
    kick(3'b111, 1, t);
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #1;
    check("s4_up", {29'b0, up}, 32'h7);
    check("s4_down", {29'b0, down}, 32'h7);
    check("s4_ds", {29'b0, ds}, 32'h7);
    check("s4_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("s4_no_done", done_cnt - dc0, 0);

`ifdef BSG_SDR_RESET_SEQ_ABORT_EN
    // Abort and start together in TOKEN_SET (cycles 4..6 for H = 2).
    dc0 = done_cnt;
    kick(3'b011, 2, t);
    repeat (3) @(negedge clk);
    abort = 1'b1; start = 1'b1; mask_in = 3'b100; hold_in = 8'd0;
    @(negedge clk);
    abort = 1'b0; start = 1'b0; mask_in = '0;
    #1;
    check("s5_busy", {31'b0, busy}, 32'd0);
    check("s5_up", {29'b0, up}, 32'h7);
    check("s5_tok", {29'b0, tok}, 32'h0);
    repeat (2) @(negedge clk); #1;
    check("s5_still_idle", {31'b0, busy}, 32'd0);
    check("s5_no_done", done_cnt - dc0, 0);
`endif

    // Maximum hold count: six phases of 256 cycles each, no early wrap.
    @(negedge clk);
    kick(3'b100, 255, t);
    wait_idle(2000);
    check("s6_done_at", last_done - t + 1, 1537);
    check("s6_ds", {29'b0, ds}, 32'h3);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
